// File: rtl/prim_clog2_seq.sv
// Sequential clog2 / vbits / pow2 unit: one shift iteration per cycle behind a
// valid/ready request and response handshake.
module prim_clog2_seq #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_mode_i,
   input  logic [Width-1:0] req_value_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [Width-1:0] rsp_result_o,
   output logic             rsp_overflow_o,
   output logic             rsp_error_o,
   output logic             busy_o
);

   localparam int unsigned CntW = $clog2(Width + 1);
   localparam logic [Width-1:0] WidthVal = Width'(Width);

   typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;
   typedef enum logic [1:0] {ModeClog2, ModeVbits, ModePow2, ModeIllegal} mode_e;

   state_e            state_q;
   mode_e             mode_q;
   logic [Width-1:0]  v_q;
   logic [Width-1:0]  result_q;
   logic [CntW-1:0]   cnt_q;
   logic              rsp_valid_q;
   logic              overflow_q;
   logic              error_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         mode_q      <= ModeClog2;
         v_q         <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  mode_q     <= mode_e'(req_mode_i);
                  v_q        <= '0;
                  result_q   <= '0;
                  cnt_q      <= '0;
                  overflow_q <= 1'b0;
                  error_q    <= 1'b0;
                  state_q    <= StCalc;
                  unique case (mode_e'(req_mode_i))
                     ModeClog2, ModeVbits: begin
                        if (req_value_i != '0) v_q <= req_value_i - Width'(1);
                        // vbits(1) is 1 rather than 0; no iterations needed
                        if (mode_e'(req_mode_i) == ModeVbits && req_value_i == Width'(1)) begin
                           result_q <= Width'(1);
                        end
                     end
                     ModePow2: begin
                        if (req_value_i < WidthVal) begin
                           result_q <= Width'(1);
                           cnt_q    <= req_value_i[CntW-1:0];
                        end else begin
                           overflow_q <= 1'b1;
                        end
                     end
                     default: error_q <= 1'b1;
                  endcase
               end
            end
            StCalc: begin
               unique case (mode_q)
                  ModeClog2, ModeVbits: begin
                     if (v_q != '0) begin
                        v_q      <= v_q >> 1;
                        result_q <= result_q + Width'(1);
                     end else begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                     end
                  end
                  ModePow2: begin
                     // Overflow loads cnt_q = 0, so it terminates here too
                     if (cnt_q != '0) begin
                        result_q <= result_q << 1;
                        cnt_q    <= cnt_q - CntW'(1);
                     end else begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                     end
                  end
                  default: begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                  end
               endcase
            end
            StResp: begin
               if (rsp_ready_i) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Gated by rst_ni so no request appears acceptable while reset is held
   assign req_ready_o    = (state_q == StIdle) && rst_ni;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_result_o   = result_q;
   assign rsp_overflow_o = overflow_q;
   assign rsp_error_o    = error_q;
   assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_prim_clog2_seq.sv
// Directed bench for prim_clog2_seq (Width = 32): hand-computed results,
// latencies, backpressure and mid-operation reset.
module tb_prim_clog2_seq;

   localparam int unsigned Width = 32;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             req_valid_i = 1'b0;
   logic             req_ready_o;
   logic [1:0]       req_mode_i = 2'd0;
   logic [Width-1:0] req_value_i = '0;
   logic             rsp_valid_o;
   logic             rsp_ready_i = 1'b1;
   logic [Width-1:0] rsp_result_o;
   logic             rsp_overflow_o;
   logic             rsp_error_o;
   logic             busy_o;

   int errors = 0;
   int checks = 0;

   prim_clog2_seq #(.Width(Width)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_mode_i     (req_mode_i),
      .req_value_i    (req_value_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_result_o   (rsp_result_o),
      .rsp_overflow_o (rsp_overflow_o),
      .rsp_error_o    (rsp_error_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one request; inputs are scrambled right after capture
   task automatic do_req(input logic [1:0] mode, input logic [31:0] value,
                         input logic [31:0] exp_res, input logic exp_ovf, input logic exp_err,
                         input int exp_lat, input string tag, input logic rdy);
      int lat;
      rsp_ready_i = rdy;
      req_mode_i  = mode;
      req_value_i = value;
      req_valid_i = 1'b1;
      check({tag, ".req_ready"}, 64'(req_ready_o), 64'd1);
      step();
      req_valid_i = 1'b0;
      req_value_i = ~value;
      req_mode_i  = mode ^ 2'b01;
      check({tag, ".busy"}, 64'(busy_o), 64'd1);
      lat = 1;
      while (!rsp_valid_o && lat < 100) begin
         step();
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".result"}, 64'(rsp_result_o), 64'(exp_res));
      check({tag, ".overflow"}, 64'(rsp_overflow_o), 64'(exp_ovf));
      check({tag, ".error"}, 64'(rsp_error_o), 64'(exp_err));
      if (rdy) begin
         step();
         check({tag, ".idle_ready"}, 64'(req_ready_o), 64'd1);
         check({tag, ".idle_valid"}, 64'(rsp_valid_o), 64'd0);
      end
   endtask

   initial begin
      // Reset
      rst_ni = 1'b0;
      step();
      step();
      check("rst.req_ready_low", 64'(req_ready_o), 64'd0);
      check("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst.result", 64'(rsp_result_o), 64'd0);
      check("rst.overflow", 64'(rsp_overflow_o), 64'd0);
      check("rst.error", 64'(rsp_error_o), 64'd0);
      check("rst.busy", 64'(busy_o), 64'd0);
      rst_ni = 1'b1;
      #1;
      check("rst.req_ready_release", 64'(req_ready_o), 64'd1);

      // Main function
      do_req(2'd0, 32'd1000, 32'd10, 1'b0, 1'b0, 12, "clog2_1000", 1'b1);
      do_req(2'd1, 32'd1, 32'd1, 1'b0, 1'b0, 2, "vbits_1", 1'b1);
      do_req(2'd0, 32'd1, 32'd0, 1'b0, 1'b0, 2, "clog2_1", 1'b1);
      do_req(2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2, "clog2_0", 1'b1);
      do_req(2'd2, 32'd5, 32'd32, 1'b0, 1'b0, 7, "pow2_5", 1'b1);
      do_req(2'd2, 32'd32, 32'd0, 1'b1, 1'b0, 2, "pow2_32", 1'b1);
      do_req(2'd3, 32'd7, 32'd0, 1'b0, 1'b1, 2, "mode3", 1'b1);
      do_req(2'd0, 32'd1024, 32'd10, 1'b0, 1'b0, 12, "clog2_1024", 1'b1);
      do_req(2'd0, 32'd1025, 32'd11, 1'b0, 1'b0, 13, "clog2_1025", 1'b1);
      do_req(2'd1, 32'd5, 32'd3, 1'b0, 1'b0, 5, "vbits_5", 1'b1);
      do_req(2'd0, 32'hFFFF_FFFF, 32'd32, 1'b0, 1'b0, 34, "clog2_max", 1'b1);
      do_req(2'd2, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 33, "pow2_31", 1'b1);
      do_req(2'd2, 32'd0, 32'd1, 1'b0, 1'b0, 2, "pow2_0", 1'b1);

      // Backpressure: response held, no new request accepted
      do_req(2'd0, 32'd64, 32'd6, 1'b0, 1'b0, 8, "clog2_64", 1'b0);
      req_valid_i = 1'b1;
      req_mode_i  = 2'd2;
      req_value_i = 32'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp.valid", 64'(rsp_valid_o), 64'd1);
         check("bp.result", 64'(rsp_result_o), 64'd6);
         check("bp.req_ready", 64'(req_ready_o), 64'd0);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      step();
      check("bp.idle_ready", 64'(req_ready_o), 64'd1);
      check("bp.idle_valid", 64'(rsp_valid_o), 64'd0);
      check("bp.idle_result", 64'(rsp_result_o), 64'd6);
      do_req(2'd2, 32'd3, 32'd8, 1'b0, 1'b0, 5, "after_bp_pow2_3", 1'b1);

      // Reset in the middle of a long POW2
      req_mode_i  = 2'd2;
      req_value_i = 32'd20;
      req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      step();
      step();
      check("midrst.busy_before", 64'(busy_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("midrst.req_ready_low", 64'(req_ready_o), 64'd0);
      step();
      rst_ni = 1'b1;
      #1;
      check("midrst.req_ready", 64'(req_ready_o), 64'd1);
      check("midrst.busy", 64'(busy_o), 64'd0);
      check("midrst.result", 64'(rsp_result_o), 64'd0);
      check("midrst.flags", 64'({rsp_overflow_o, rsp_error_o}), 64'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 25; i++) begin
            step();
            if (rsp_valid_o) seen++;
         end
         check("midrst.no_response", 64'(seen), 64'd0);
      end
      do_req(2'd0, 32'd2, 32'd1, 1'b0, 1'b0, 3, "clog2_2", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
